// File: rtl/control_busqueda_pkg.sv
// Types, widths and the fetch-address legality rule used by the fetch
// sequencer and its byte assembler.
package control_busqueda_pkg;

  localparam int INSTR_W         = 32;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_INSTR = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_FAULT
  } estado_t;

  // Word aligned and the whole word lies inside memory.
  function automatic logic legal_pc(input logic [31:0] pc, input logic [31:0] mem_bytes);
    return (pc[1:0] == 2'b00) && (pc <= mem_bytes - 32'(BYTES_PER_INSTR));
  endfunction

endpackage

// File: rtl/control_busqueda_ensamblador_bytes.sv
// Shifts in one byte per cycle and presents the 32-bit big-endian word
// formed by the three buffered bytes plus the byte arriving this cycle.
module ensamblador_bytes
  import control_busqueda_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_shift,
  input  logic [BYTE_W-1:0]  i_byte,
  output logic [1:0]         o_cnt,
  output logic [INSTR_W-1:0] o_word,
  output logic               o_last
);

  logic [INSTR_W-BYTE_W-1:0] r_buf;
  logic [1:0]                r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_buf <= {r_buf[INSTR_W-2*BYTE_W-1:0], i_byte};
      r_cnt <= r_cnt + 2'd1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_word = {r_buf, i_byte};
  assign o_last = (r_cnt == 2'd3);

endmodule

// File: rtl/control_busqueda.sv
// Instruction-fetch sequencer: owns the PC, reads four bytes per instruction
// from a byte-wide memory and hands the word to decode with valid/ready.
module control_busqueda
  import control_busqueda_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic [31:0]         mem_addr,
  input  logic [BYTE_W-1:0]   mem_rdata,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [31:0]         instr_pc,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                fault,
  output logic                busy
);

  localparam logic [31:0] LP_MEM = 32'(MEM_BYTES);

  estado_t              r_state, w_state_nxt;
  logic [31:0]          r_pc, w_pc_nxt, w_pc_inc;
  logic [INSTR_W-1:0]   r_instr;
  logic [31:0]          r_instr_pc;
  logic                 w_load, w_clr, w_shift, w_last;
  logic [1:0]           w_cnt;
  logic [INSTR_W-1:0]   w_word;

  ensamblador_bytes u_ensamblador (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_clr),
    .i_shift (w_shift),
    .i_byte  (mem_rdata),
    .o_cnt   (w_cnt),
    .o_word  (w_word),
    .o_last  (w_last)
  );

  assign w_pc_inc = r_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= PC_RESET;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_load) begin
        r_instr    <= w_word;
        r_instr_pc <= r_pc;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    // A redirect wins in every state, including FAULT, and also completes a
    // pending handshake in HOLD (pc takes the target rather than pc+4).
    if (redirect_valid) begin
      w_pc_nxt = redirect_pc;
      w_clr    = 1'b1;
      if (!legal_pc(redirect_pc, LP_MEM)) w_state_nxt = ST_FAULT;
      else                                w_state_nxt = en ? ST_FETCH : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) w_state_nxt = legal_pc(r_pc, LP_MEM) ? ST_FETCH : ST_FAULT;
        end
        ST_FETCH: begin
          w_shift = 1'b1;
          if (w_last) begin
            w_load      = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            w_pc_nxt = w_pc_inc;
            if (!legal_pc(w_pc_inc, LP_MEM)) w_state_nxt = ST_FAULT;
            else                             w_state_nxt = en ? ST_FETCH : ST_IDLE;
          end
        end
        ST_FAULT: ;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign mem_addr    = r_pc + {30'd0, w_cnt};
  assign instr_valid = (r_state == ST_HOLD);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign fault       = (r_state == ST_FAULT);
  assign busy        = (r_state == ST_FETCH);

endmodule

// File: tb/tb_control_busqueda.sv
// Bench for control_busqueda: directed scenarios then random en/ready/redirect
// traffic, every cycle compared against a transaction-level fetch model.
module tb_control_busqueda;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic        busy;

  logic [7:0] mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  // model: fetched byte count k (-1 when not fetching), holding flag, fault flag
  logic [31:0] m_pc, m_instr, m_ipc;
  int          m_k;
  bit          m_hold, m_fault;

  always #5 clk = ~clk;

  always_comb mem_rdata = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 8'h00;

  control_busqueda #(.PC_RESET(32'h0), .MEM_BYTES(256)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a <= 32'd252);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem[a[7:0]], mem[a[7:0]+8'd1], mem[a[7:0]+8'd2], mem[a[7:0]+8'd3]};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    m_k = -1; m_hold = 0; m_fault = 0;
  endtask

  task automatic model_step();
    if (redirect_valid) begin
      m_pc   = redirect_pc;
      m_hold = 0;
      if (is_legal(redirect_pc)) begin
        m_fault = 0;
        m_k     = en ? 0 : -1;
      end else begin
        m_fault = 1;
        m_k     = -1;
      end
    end else if (m_fault) begin
      // stays faulted
    end else if (m_hold) begin
      if (instr_ready) begin
        m_hold = 0;
        m_pc   = m_pc + 32'd4;
        if (is_legal(m_pc)) m_k = en ? 0 : -1;
        else                m_fault = 1;
      end
    end else if (m_k >= 0) begin
      if (m_k == 3) begin
        m_hold  = 1;
        m_instr = word_at(m_pc);
        m_ipc   = m_pc;
        m_k     = -1;
      end else begin
        m_k++;
      end
    end else if (en) begin
      if (is_legal(m_pc)) m_k = 0;
      else                m_fault = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".mem_addr"}, mem_addr, m_pc + 32'((m_k > 0) ? m_k : 0));
    chk({tag, ".valid"},    {31'd0, instr_valid}, {31'd0, m_hold});
    chk({tag, ".fault"},    {31'd0, fault}, {31'd0, m_fault});
    chk({tag, ".busy"},     {31'd0, busy}, {31'd0, (m_k >= 0)});
    chk({tag, ".instr"},    instr, m_instr);
    chk({tag, ".instr_pc"}, instr_pc, m_ipc);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs("cyc");
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_hold(input string tag);
    int t = 0;
    while (!m_hold && t < 20) begin cycle(); t++; end
    chk({tag, ".reached"}, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;

    rst_n = 1'b0; en = 1'b1; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;

    // first word, held for several cycles with ready low
    run(12);
    chk("first.instr", instr, 32'h1234_5678);
    chk("first.pc", instr_pc, 32'h0);
    chk("first.valid", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    chk("next.addr", mem_addr, 32'h4);

    // redirect with two bytes of the word already gathered
    begin
      int t = 0;
      while (m_k != 2 && t < 10) begin cycle(); t++; end
    end
    chk("mid.busy", {31'd0, busy}, 32'd1);
    pulse_redirect(32'h20);
    wait_hold("redir20");
    chk("redir20.pc", instr_pc, 32'h20);
    chk("redir20.instr", instr, word_at(32'h20));
    instr_ready = 1'b1; cycle(); instr_ready = 1'b0;

    // misaligned redirect faults, legal redirect recovers
    pulse_redirect(32'h22);
    run(3);
    chk("mis.fault", {31'd0, fault}, 32'd1);
    chk("mis.valid", {31'd0, instr_valid}, 32'd0);
    chk("mis.addr", mem_addr, 32'h22);
    pulse_redirect(32'h40);
    chk("rec.fault", {31'd0, fault}, 32'd0);
    wait_hold("rec40");
    chk("rec40.pc", instr_pc, 32'h40);

    // last legal word then sequential overrun
    instr_ready = 1'b1;
    pulse_redirect(32'd252);
    instr_ready = 1'b0;
    wait_hold("w252");
    chk("w252.pc", instr_pc, 32'd252);
    instr_ready = 1'b1; cycle(); instr_ready = 1'b0;
    run(2);
    chk("end.fault", {31'd0, fault}, 32'd1);
    chk("end.addr", mem_addr, 32'd256);

    // asynchronous reset while holding a word
    pulse_redirect(32'h10);
    wait_hold("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    rst_n = 1'b1;
    wait_hold("post_rst");
    chk("post_rst.pc", instr_pc, 32'h0);
    chk("post_rst.instr", instr, 32'h1234_5678);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      en          = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 1) != 0);
      if (!redirect_valid && $urandom_range(0, 11) == 0) begin
        redirect_valid = 1'b1;
        r = $urandom_range(0, 9);
        if (r < 7)       redirect_pc = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
        else if (r == 7) redirect_pc = {22'd0, 8'($urandom_range(0, 63)), 2'b10};
        else if (r == 8) redirect_pc = 32'd256 + 32'(4 * $urandom_range(0, 15));
        else             redirect_pc = 32'hFFFF_FFFC;
      end else begin
        redirect_valid = 1'b0;
      end
      cycle();
    end
    redirect_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_busqueda.md
Name: control_busqueda

Overview:
- Instruction-fetch sequencer in front of the byte-wide instruction memory (8-bit entries, 32-bit big-endian instructions at byte addresses).
- Owns the PC and reads four consecutive bytes over four cycles through a single-byte combinational read port.
- Assembles each instruction and presents it to decode with a valid/ready handshake.
- Handles branch redirects, and faults on misaligned or out-of-range fetch addresses.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded at reset; must be 4-aligned.
- MEM_BYTES, 256, instruction memory size in bytes; a fetch is legal iff pc[1:0]==0 and pc <= MEM_BYTES-4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  fetch enable; sampled only in IDLE and when HOLD completes.
- mem_addr  out  32  byte address to instruction memory; equals pc + byte_cnt.
- mem_rdata  in  8  byte returned combinationally for mem_addr in the same cycle.
- instr_valid  out  1  assembled instruction is available.
- instr_ready  in  1  decode accepts the instruction.
- instr  out  32  assembled instruction; byte at pc is bits [31:24].
- instr_pc  out  32  address of instr.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  32  new fetch target.
- fault  out  1  sticky illegal fetch address indication.
- busy  out  1  high in FETCH.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=PC_RESET, byte_cnt=0, shift buffer=0.
  - instr_valid=0, instr=0, instr_pc=0, fault=0, busy=0, mem_addr=PC_RESET.
- State encoding: IDLE, FETCH, HOLD, FAULT, defined in the shared package.
- IDLE:
  - If en=1 and pc is legal, go to FETCH with byte_cnt=0.
  - If en=1 and pc is illegal, go to FAULT.
- FETCH:
  - Each cycle: buf <= {buf[23:0], mem_rdata}; byte_cnt++ (2-bit, wraps).
  - When byte_cnt==3, go to HOLD next cycle with instr={buf[23:0],mem_rdata}, instr_pc=pc, instr_valid=1.
  - Latency: instr_valid rises exactly 4 cycles after FETCH is entered.
  - en is ignored mid-word; the word always completes.
- HOLD:
  - instr, instr_pc and instr_valid stay stable until instr_ready=1.
  - On the accept cycle, pc <= pc+4 and instr_valid drops next cycle.
  - If the new pc is illegal, go to FAULT. Else go to FETCH if en=1, otherwise IDLE.
  - Back-to-back throughput: one instruction per 5 cycles.
- Redirect (redirect_valid=1) has highest priority in IDLE, FETCH and HOLD:
  - pc <= redirect_pc, byte_cnt <= 0, partial buffer discarded, instr_valid <= 0 next cycle.
  - In HOLD with instr_ready=1 in the same cycle, the handshake counts as completed, but pc takes redirect_pc, not pc+4.
  - Next state is FAULT if redirect_pc is illegal, FETCH if en=1, otherwise IDLE.
- FAULT:
  - fault=1, instr_valid=0, busy=0; mem_addr holds the offending pc.
  - Exits only on a legal redirect (to FETCH if en=1, else IDLE; fault clears next cycle) or on reset.
  - An illegal redirect in FAULT updates pc and stays in FAULT.
- Arithmetic:
  - pc+4 and pc+byte_cnt are 32-bit unsigned.
  - The range check uses unsigned compare, so 32'hFFFF_FFFC+4 wrapping to 0 is never produced because the check precedes the increment.
- Reset asserted mid-FETCH or mid-HOLD aborts immediately, with no partial instr visible.

Decomposition:
- Shared package:
  - State enum.
  - Width constants: INSTR_W=32, BYTE_W=8, BYTES_PER_INSTR=4.
  - Legality function legal_pc(pc, MEM_BYTES).
- One natural sub-module: ensamblador_bytes, the 4-byte shift/assemble register with byte counter and clear. The FSM and PC stay in control_busqueda.

Test Plan:
- Reset release with en=1, memory bytes 0..3 = 8'h12,8'h34,8'h56,8'h78 -> mem_addr steps 0,1,2,3; instr_valid rises on the 4th edge after FETCH entry with instr=32'h12345678 and instr_pc=0.
- instr_ready held 0 for 6 cycles -> instr and instr_pc stable and instr_valid=1 throughout; ready=1 -> next fetch starts at mem_addr=4.
- redirect_valid pulsed with redirect_pc=32'h20 when byte_cnt=2 -> partial word discarded; next instr_pc=32'h20 with bytes from 0x20..0x23.
- redirect_pc=32'h22 -> fault=1 and instr_valid=0; then redirect_pc=32'h40 -> fault clears and fetch resumes at 0x40.
- Sequential fetch at pc=MEM_BYTES-4=252 accepted -> pc=256, FAULT entered, fault=1.
- rst_n asserted in HOLD -> outputs immediately return to reset values; after release, fetch restarts at PC_RESET.
